// File: rtl/host_tick_service_if.sv
// rtl/host_tick_service_if.sv - Avalon-MM style bus bundle used for the timer master and CPU slave ports
//
// Purpose: groups one Avalon-MM word-addressed 16-bit bus.
// Signals:
//   address      word address, ADDR_W bits
//   chipselect   transfer select
//   write_n      write strobe, active low (read when chipselect=1 and write_n=1)
//   writedata    16-bit write data
//   readdata     16-bit read data, returned by the slave
//   waitrequest  slave stall
// Modports:
//   master  drives address/chipselect/write_n/writedata, observes waitrequest
//   slave   observes address/chipselect/write_n/writedata, drives readdata/waitrequest

interface host_tick_service_if #(
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;
    logic              waitrequest;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output waitrequest
    );
endinterface

// File: rtl/host_tick_service.sv
// rtl/host_tick_service.sv - hardware service of the interval-timer interrupt with tick count and alarm
//
// Purpose: on each timer_irq, writes 0 to the timer status register over the master bus
// to clear the timeout, counts serviced ticks in a free-running 32-bit counter, and
// optionally counts down a one-shot alarm. The CPU reads tick/alarm state over the slave bus.
// Optional feature macro: HOST_TICK_ALARM_EN (alarm countdown, flag, ie, irq).
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   timer_irq  level interrupt from the interval timer
//   m_bus      master bus to the timer (3-bit word address, write-only)
//   s_bus      CPU slave bus (2-bit word address), readdata registered, never stalls
//   irq        alarm interrupt to the CPU (flag & ie, registered); 0 without the alarm
// Slave map: 0 TICK_LO (read latches TICK_HI shadow, write clears tick),
//            1 TICK_HI shadow, 2 ALARM count, 3 STATUS {armed, ie, flag}.

module host_tick_service #(
    parameter logic [2:0] TIMER_STATUS_ADDR = 3'd0,
    parameter int         ALARM_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   timer_irq,
    host_tick_service_if.master    m_bus,
    host_tick_service_if.slave     s_bus,
    output logic                   irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] tick_q, tick_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] readdata_q, readdata_d;
    logic [15:0] alarm_rd;
    logic [15:0] status_rd;

    logic accept;
    logic slv_rd;
    logic slv_wr;

    // The timer write completes on the edge where it is presented without a stall.
    assign accept = (state_q == ST_CLEAR) && !m_bus.waitrequest;
    assign slv_rd = s_bus.chipselect &&  s_bus.write_n;
    assign slv_wr = s_bus.chipselect && !s_bus.write_n;

    // Master outputs decode straight from the state flop so that reset removes
    // the write asynchronously.
    assign m_bus.chipselect = (state_q == ST_CLEAR);
    assign m_bus.write_n    = (state_q != ST_CLEAR);
    assign m_bus.address    = TIMER_STATUS_ADDR;
    assign m_bus.writedata  = 16'h0000;

    assign s_bus.waitrequest = 1'b0;
    assign s_bus.readdata    = readdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (timer_irq) state_d = ST_CLEAR;
            ST_CLEAR:  if (accept)    state_d = ST_SETTLE;
            // The timer irq line may still be high for a cycle after the clear.
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_d   = tick_q;
        shadow_d = shadow_q;
        if (accept) begin
            tick_d = tick_q + 32'd1;
        end
        // The shadow captures the pre-increment upper half, matching the low half
        // returned by the same read.
        if (slv_rd && (s_bus.address == 2'd0)) begin
            shadow_d = tick_q[31:16];
        end
        // A CPU clear takes priority over a coincident increment.
        if (slv_wr && (s_bus.address == 2'd0)) begin
            tick_d   = 32'd0;
            shadow_d = 16'd0;
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (slv_rd) begin
            case (s_bus.address)
                2'd0:    readdata_d = tick_q[15:0];
                2'd1:    readdata_d = shadow_q;
                2'd2:    readdata_d = alarm_rd;
                default: readdata_d = status_rd;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tick_q     <= 32'd0;
            shadow_q   <= 16'd0;
            readdata_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            shadow_q   <= shadow_d;
            readdata_q <= readdata_d;
        end
    end

`ifdef HOST_TICK_ALARM_EN
    logic [ALARM_W-1:0] alarm_q, alarm_d;
    logic               flag_q, flag_d;
    logic               ie_q, ie_d;
    logic               irq_q, irq_d;

    always_comb begin
        alarm_d = alarm_q;
        flag_d  = flag_q;
        ie_d    = ie_q;
        if (slv_wr && (s_bus.address == 2'd3)) begin
            if (s_bus.writedata[0]) flag_d = 1'b0;
            ie_d = s_bus.writedata[1];
        end
        // A CPU load replaces any decrement on the same edge; expiry is evaluated
        // after the flag clear so that a coincident expiry still sets the flag.
        if (slv_wr && (s_bus.address == 2'd2)) begin
            alarm_d = s_bus.writedata[ALARM_W-1:0];
        end else if (accept && (alarm_q != '0)) begin
            alarm_d = alarm_q - ALARM_W'(1);
            if (alarm_q == ALARM_W'(1)) flag_d = 1'b1;
        end
        irq_d = flag_d & ie_d;

        alarm_rd              = 16'd0;
        alarm_rd[ALARM_W-1:0] = alarm_q;
        status_rd             = {13'd0, (alarm_q != '0), ie_q, flag_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_q <= '0;
            flag_q  <= 1'b0;
            ie_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
            flag_q  <= flag_d;
            ie_q    <= ie_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    always_comb begin
        alarm_rd  = 16'd0;
        status_rd = 16'd0;
    end

    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_host_tick_service.sv
// tb/tb_host_tick_service.sv - self-checking bench for host_tick_service

module tb_host_tick_service;

    logic clk = 1'b0;
    logic reset_n;
    logic timer_irq;
    logic irq;

    host_tick_service_if #(.ADDR_W(3)) m_bus ();
    host_tick_service_if #(.ADDR_W(2)) s_bus ();

    assign m_bus.readdata = 16'h0000;

    host_tick_service #(
        .TIMER_STATUS_ADDR (3'd0),
        .ALARM_W           (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .timer_irq (timer_irq),
        .m_bus     (m_bus),
        .s_bus     (s_bus),
        .irq       (irq)
    );

    always #5 clk = ~clk;

`ifdef HOST_TICK_ALARM_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: what the CPU should observe.
    logic [31:0] m_tick;
    logic [15:0] m_shadow;
    logic [15:0] m_alarm;
    bit          m_flag;
    bit          m_ie;

    typedef struct {
        int          op;     // 0 read, 1 write, 2 serviced tick
        logic [1:0]  a;
        logic [15:0] d;
        logic [15:0] expv;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_tick = 0; m_shadow = 0; m_alarm = 0; m_flag = 0; m_ie = 0;
    endtask

    task automatic model_read(input logic [1:0] a, output logic [15:0] v);
        case (a)
            2'd0: begin v = m_tick[15:0]; m_shadow = m_tick[31:16]; end
            2'd1: v = m_shadow;
            2'd2: v = AL ? m_alarm : 16'h0;
            default: v = AL ? {13'd0, (m_alarm != 0), m_ie, m_flag} : 16'h0;
        endcase
    endtask

    task automatic model_write(input logic [1:0] a, input logic [15:0] d);
        if (a == 2'd0) begin m_tick = 0; m_shadow = 0; end
        if (AL && a == 2'd2) m_alarm = d;
        if (AL && a == 2'd3) begin
            if (d[0]) m_flag = 0;
            m_ie = d[1];
        end
    endtask

    task automatic model_accept(input bit tick_clr, input bit alarm_ld);
        if (!tick_clr) m_tick = m_tick + 1;
        if (AL && !alarm_ld && m_alarm != 0) begin
            m_alarm = m_alarm - 1;
            if (m_alarm == 0) m_flag = 1;
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        s_bus.chipselect = 1; s_bus.write_n = 0; s_bus.address = a; s_bus.writedata = d;
        @(negedge clk);
        s_bus.chipselect = 0; s_bus.write_n = 1;
        model_write(a, d);
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [15:0] v);
        @(negedge clk);
        s_bus.chipselect = 1; s_bus.write_n = 1; s_bus.address = a;
        @(negedge clk);
        s_bus.chipselect = 0;
        v = s_bus.readdata;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a);
        logic [15:0] v, e;
        cpu_read(a, v);
        model_read(a, e);
        check(name, v, e);
    endtask

    // One serviced tick: wcyc stall cycles, optional CPU op (1 write, 2 read) on the accept edge.
    task automatic service(input int wcyc, input int op, input logic [1:0] a,
                           input logic [15:0] d, input string name);
        int cnt; bit bad; bit done;
        logic [15:0] v, e;
        cnt = 0; bad = 0; done = 0;
        @(negedge clk);
        timer_irq = 1; m_bus.waitrequest = (wcyc > 0);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (m_bus.chipselect) begin
                cnt++;
                if (m_bus.write_n !== 1'b0 || m_bus.address !== 3'd0 || m_bus.writedata !== 16'h0)
                    bad = 1;
                if (cnt > wcyc) begin
                    m_bus.waitrequest = 0; timer_irq = 0;
                    if (op == 1) begin
                        s_bus.chipselect = 1; s_bus.write_n = 0; s_bus.address = a; s_bus.writedata = d;
                    end else if (op == 2) begin
                        s_bus.chipselect = 1; s_bus.write_n = 1; s_bus.address = a;
                    end
                end
            end else if (cnt > 0) begin
                done = 1;
            end
        end
        v = s_bus.readdata;
        s_bus.chipselect = 0; s_bus.write_n = 1;
        timer_irq = 0; m_bus.waitrequest = 0;
        check({name, "_done"}, done, 1);
        check({name, "_len"}, cnt, wcyc + 1);
        check({name, "_bus"}, bad, 0);
        if (op == 1) model_write(a, d);
        if (op == 2) model_read(a, e);
        model_accept(op == 1 && a == 2'd0, op == 1 && a == 2'd2);
        if (op == 2) check({name, "_rd"}, v, e);
        @(negedge clk);
    endtask

    task automatic irq_check(input string name);
        check(name, irq, AL ? (m_flag & m_ie) : 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        int n;
        bit seen;

        reset_n = 0; timer_irq = 0; m_bus.waitrequest = 0;
        s_bus.chipselect = 0; s_bus.write_n = 1; s_bus.address = 0; s_bus.writedata = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_cs", m_bus.chipselect, 0);
        check("rst_wn", m_bus.write_n, 1);
        check("rst_addr", m_bus.address, 3'd0);
        check("rst_wdata", m_bus.writedata, 16'h0);
        check("rst_rdata", s_bus.readdata, 16'h0);
        check("rst_irq", irq, 0);
        reset_n = 1;

        // Table-driven basic sequence.
        tbl.push_back('{0, 2'd0, 16'h0, 16'h0});
        tbl.push_back('{0, 2'd3, 16'h0, 16'h0});
        tbl.push_back('{2, 2'd0, 16'h0, 16'h0});
        tbl.push_back('{2, 2'd0, 16'h0, 16'h0});
        tbl.push_back('{2, 2'd0, 16'h0, 16'h0});
        tbl.push_back('{0, 2'd0, 16'h0, 16'h3});
        tbl.push_back('{0, 2'd1, 16'h0, 16'h0});
        tbl.push_back('{1, 2'd0, 16'hBEEF, 16'h0});
        tbl.push_back('{0, 2'd0, 16'h0, 16'h0});
        tbl.push_back('{1, 2'd2, 16'h2, 16'h0});
        tbl.push_back('{0, 2'd2, 16'h0, AL ? 16'h2 : 16'h0});
        tbl.push_back('{0, 2'd3, 16'h0, AL ? 16'h4 : 16'h0});
        tbl.push_back('{2, 2'd0, 16'h0, 16'h0});
        tbl.push_back('{0, 2'd2, 16'h0, AL ? 16'h1 : 16'h0});
        tbl.push_back('{2, 2'd0, 16'h0, 16'h0});
        tbl.push_back('{0, 2'd3, 16'h0, AL ? 16'h1 : 16'h0});
        tbl.push_back('{1, 2'd3, 16'h1, 16'h0});
        tbl.push_back('{0, 2'd3, 16'h0, 16'h0});
        tbl.push_back('{0, 2'd0, 16'h0, 16'h2});
        tbl.push_back('{0, 2'd1, 16'h0, 16'h0});

        foreach (tbl[i]) begin
            logic [15:0] e;
            case (tbl[i].op)
                0: begin
                    cpu_read(tbl[i].a, v);
                    model_read(tbl[i].a, e);
                    check($sformatf("tbl%0d_rd", i), v, tbl[i].expv);
                end
                1: cpu_write(tbl[i].a, tbl[i].d);
                default: service(0, 0, 2'd0, 16'h0, $sformatf("tbl%0d_tick", i));
            endcase
        end

        // Stalled clear: 4 waitrequest cycles, 5 cycles of stable write, one tick.
        rd_check("stall_pre", 2'd0);
        service(4, 0, 2'd0, 16'h0, "stall");
        rd_check("stall_post", 2'd0);

        // Timer irq held high: one service per three cycles.
        @(negedge clk);
        timer_irq = 1; m_bus.waitrequest = 0; n = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_bus.chipselect) n++;
        end
        timer_irq = 0;
        check("held_irq_count", n, 4);
        repeat (4) model_accept(0, 0);
        repeat (2) @(negedge clk);
        rd_check("held_irq_tick", 2'd0);

        // Shadow coherence across a 16-bit carry.
        @(negedge clk);
        force dut.tick_q = 32'h0000_FFFF;
        #1 release dut.tick_q;
        m_tick = 32'h0000_FFFF;
        cpu_read(2'd0, v); model_read(2'd0, v);
        check("carry_lo_pre", v, 16'hFFFF);
        service(0, 0, 2'd0, 16'h0, "carry");
        rd_check("carry_hi_shadow", 2'd1);
        cpu_read(2'd0, v); model_read(2'd0, v);
        check("carry_lo_post", v, 16'h0000);
        cpu_read(2'd1, v);
        check("carry_hi_post", v, 16'h0001);
        m_shadow = 16'h0001;

        // 32-bit wrap.
        @(negedge clk);
        force dut.tick_q = 32'hFFFF_FFFF;
        #1 release dut.tick_q;
        m_tick = 32'hFFFF_FFFF;
        service(0, 0, 2'd0, 16'h0, "wrap");
        rd_check("wrap_lo", 2'd0);
        rd_check("wrap_hi", 2'd1);

        // Coincident CPU access on the accept edge.
        service(0, 0, 2'd0, 16'h0, "pre_coinc");
        service(0, 1, 2'd0, 16'h1234, "clr_on_accept");
        rd_check("clr_on_accept_lo", 2'd0);
        service(0, 1, 2'd2, 16'h5, "alarm_on_accept");
        rd_check("alarm_on_accept_rd", 2'd2);
        service(1, 2, 2'd0, 16'h0, "rd_on_accept");
        rd_check("rd_on_accept_hi", 2'd1);

        // Alarm expiry and interrupt.
        cpu_write(2'd2, 16'd3);
        cpu_write(2'd3, 16'd2);
        service(0, 0, 2'd0, 16'h0, "al1");
        service(0, 0, 2'd0, 16'h0, "al2");
        check("alarm_irq_before", irq, 0);
        service(0, 0, 2'd0, 16'h0, "al3");
        check("alarm_irq_after", irq, AL);
        cpu_write(2'd3, 16'd3);
        check("alarm_irq_cleared", irq, 0);
        cpu_read(2'd3, v); model_read(2'd3, v);
        check("alarm_status", v, AL ? 16'h2 : 16'h0);

        // Flag clear coincident with expiry: the expiry sets the flag.
        cpu_write(2'd2, 16'd1);
        service(0, 1, 2'd3, 16'h3, "clr_vs_expiry");
        rd_check("clr_vs_expiry_st", 2'd3);
        irq_check("clr_vs_expiry_irq");
        cpu_write(2'd3, 16'h1);

        // Reset in the middle of a stalled clear.
        @(negedge clk);
        timer_irq = 1; m_bus.waitrequest = 1; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_bus.chipselect) seen = 1;
        end
        check("rst_mid_seen", seen, 1);
        #2 reset_n = 0;
        #1;
        check("rst_mid_cs", m_bus.chipselect, 0);
        check("rst_mid_wn", m_bus.write_n, 1);
        @(negedge clk);
        m_bus.waitrequest = 0;
        reset_n = 1;
        model_reset();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_bus.chipselect) begin seen = 1; timer_irq = 0; end
        end
        check("rst_reservice", seen, 1);
        @(negedge clk);
        check("rst_reservice_done", m_bus.chipselect, 0);
        model_accept(0, 0);
        @(negedge clk);
        rd_check("rst_tick", 2'd0);
        irq_check("rst_irq_after");

        // Randomized traffic against the reference.
        for (int it = 0; it < 200; it++) begin
            int kind;
            logic [1:0] a;
            logic [15:0] d;
            kind = $urandom_range(0, 2);
            a = 2'($urandom_range(0, 3));
            d = (a == 2'd2) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            case (kind)
                0: service($urandom_range(0, 3), $urandom_range(0, 2), a, d, $sformatf("rnd%0d_svc", it));
                1: cpu_write(a, d);
                default: rd_check($sformatf("rnd%0d_rd", it), a);
            endcase
            irq_check($sformatf("rnd%0d_irq", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
